// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-segment scanner with PWM brightness, leading-zero suppression
// and frame-synchronous loading of display data.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SUB_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_en,
  input  logic [3:0]              brightness,
  input  logic                    load,
  output logic [7:0]              anode,
  output logic [7:0]              cathode,
  output logic                    load_ack,
  output logic                    frame_tick
);

  localparam int SW = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(SUB_CYCLES - 1);
  localparam logic [2:0] DIG_LAST = 3'(NUM_DIGITS - 1);

  logic [SW-1:0] sub;
  logic [3:0]    ph;
  logic [2:0]    dig;
  logic          boundary;

  logic [4*NUM_DIGITS-1:0] st_digits, sh_digits;
  logic [NUM_DIGITS-1:0]   st_dp, sh_dp, st_blank, sh_blank;
  logic                    st_lz, sh_lz;
  logic [3:0]              st_bright, sh_bright;
  logic                    pending;

  logic [NUM_DIGITS-1:0] supp;
  logic                  lead;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_hide;
  logic                  lit;
  logic [7:0]            next_anode;
  logic [7:0]            next_cathode;

  assign boundary = (sub == '0) && (ph == 4'd0) && (dig == 3'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub <= '0;
      ph  <= 4'd0;
      dig <= 3'd0;
    end else if (sub == SUB_LAST) begin
      sub <= '0;
      if (ph == 4'd15) begin
        ph  <= 4'd0;
        dig <= (dig == DIG_LAST) ? 3'd0 : dig + 3'd1;
      end else begin
        ph <= ph + 4'd1;
      end
    end else begin
      sub <= sub + 1'b1;
    end
  end

  // Staging takes every load; shadow only changes at a frame boundary so a frame never tears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_digits <= '0;
      st_dp     <= '0;
      st_blank  <= '0;
      st_lz     <= 1'b0;
      st_bright <= 4'hF;
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      sh_lz     <= 1'b0;
      sh_bright <= 4'hF;
      pending   <= 1'b0;
    end else begin
      if (boundary && pending) begin
        sh_digits <= st_digits;
        sh_dp     <= st_dp;
        sh_blank  <= st_blank;
        sh_lz     <= st_lz;
        sh_bright <= st_bright;
      end
      if (load) begin
        st_digits <= digits;
        st_dp     <= dp;
        st_blank  <= blank;
        st_lz     <= lz_en;
        st_bright <= brightness;
        pending   <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // A digit is a leading zero while it and everything above it are zero with no dp.
  always_comb begin
    supp     = '0;
    lead     = sh_lz;
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_hide = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lead = lead && (sh_digits[4*i +: 4] == 4'h0) && !sh_dp[i];
      if (i > 0) supp[i] = lead;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig == 3'(i)) begin
        cur_nib  = sh_digits[4*i +: 4];
        cur_dp   = sh_dp[i];
        cur_hide = sh_blank[i] | supp[i];
      end
    end
    lit          = (ph != 4'd0) && (ph <= sh_bright) && !cur_hide;
    next_anode   = lit ? ~(8'h01 << dig) : 8'hFF;
    next_cathode = lit ? {~cur_dp, hex7(cur_nib)} : 8'hFF;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anode      <= 8'hFF;
      cathode    <= 8'hFF;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      anode      <= next_anode;
      cathode    <= next_cathode;
      load_ack   <= boundary && pending;
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: stimulus queues per-slot expectations,
// monitors summarise each displayed slot and compare against them.
module tb_seven_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int SC = 2;
  localparam int SLOT = 16 * SC;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic        lz_en = 1'b0;
  logic [3:0]  brightness = 4'hF;
  logic        load = 1'b0;
  logic [7:0]  anode;
  logic [7:0]  cathode;
  logic        load_ack;
  logic        frame_tick;

  seven_seg_scan_ctrl #(.NUM_DIGITS(ND), .SUB_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .digits(digits), .dp(dp), .blank(blank),
    .lz_en(lz_en), .brightness(brightness), .load(load), .anode(anode),
    .cathode(cathode), .load_ack(load_ack), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] ca;
    logic [7:0] cnt;
    logic [7:0] first;
    logic       clean;
  } slot_t;

  slot_t       slot_q[$];
  bit          ack_q[$];
  logic [17:0] rst_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic slot_t lit(input logic [7:0] an, input logic [7:0] ca, input int cnt);
    slot_t s;
    s.an = an; s.ca = ca; s.cnt = 8'(cnt); s.first = 8'd2; s.clean = 1'b1;
    return s;
  endfunction

  function automatic slot_t dark();
    slot_t s;
    s.an = 8'hFF; s.ca = 8'hFF; s.cnt = 8'd0; s.first = 8'hFF; s.clean = 1'b1;
    return s;
  endfunction

  // Slot monitor: summarises every slot after a frame_tick and checks frame spacing and acks.
  int    pos = 0;
  int    sc;
  bit    synced = 1'b0;
  slot_t obs;
  slot_t exp_s;

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      synced = 1'b0;
    end else begin
      if (load_ack === 1'b1) begin
        if (ack_q.size() == 0) checkOutput("load_ack_unexpected", 64'(load_ack), 64'd0);
        else checkOutput("load_ack_on_frame", 64'(frame_tick), 64'(ack_q.pop_front()));
      end
      if (frame_tick === 1'b1) begin
        if (synced) checkOutput("frame_period", 64'(pos + 1), 64'(FRAME));
        synced = 1'b1;
        pos = 0;
      end else begin
        pos++;
      end
      if (synced) begin
        sc = pos % SLOT;
        if (sc == 0) obs = dark();
        if (anode !== 8'hFF) begin
          if (obs.cnt == 8'd0) begin
            obs.an = anode;
            obs.ca = cathode;
            obs.first = 8'(sc);
          end else if (anode !== obs.an || cathode !== obs.ca) begin
            obs.clean = 1'b0;
          end
          obs.cnt = obs.cnt + 8'd1;
        end else if (cathode !== 8'hFF) begin
          obs.clean = 1'b0;
        end
        if (sc == SLOT - 1 && slot_q.size() > 0) begin
          exp_s = slot_q.pop_front();
          checkOutput($sformatf("slot%0d", pos / SLOT), 64'(obs), 64'(exp_s));
        end
      end
    end
  end

  always @(negedge reset) begin
    #1;
    if (rst_q.size() > 0)
      checkOutput("reset_outputs", 64'({anode, cathode, load_ack, frame_tick}), 64'(rst_q.pop_front()));
  end

  task automatic applyStimulus(input logic [15:0] dg, input logic [3:0] d, input logic [3:0] b,
                               input logic lz, input logic [3:0] br, input bit strobe);
    @(negedge clk);
    digits = dg; dp = d; blank = b; lz_en = lz; brightness = br; load = strobe;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic waitFrame(input string why);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 3 * FRAME);
    checkOutput(why, 64'(frame_tick), 64'd1);
  endtask

  task automatic waitAck(input string why);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (load_ack !== 1'b1 && n < 3 * FRAME);
    checkOutput(why, 64'(load_ack), 64'd1);
  endtask

  task automatic pushFrame(input slot_t s0, input slot_t s1, input slot_t s2, input slot_t s3);
    slot_q.push_back(s0);
    slot_q.push_back(s1);
    slot_q.push_back(s2);
    slot_q.push_back(s3);
  endtask

  task automatic loadAndExpect(input logic [15:0] dg, input logic [3:0] d, input logic [3:0] b,
                               input logic lz, input logic [3:0] br, input string why,
                               input slot_t s0, input slot_t s1, input slot_t s2, input slot_t s3);
    ack_q.push_back(1'b1);
    applyStimulus(dg, d, b, lz, br, 1'b1);
    waitAck(why);
    pushFrame(s0, s1, s2, s3);
  endtask

  initial begin
    int n;
    rst_q.push_back({8'hFF, 8'hFF, 2'b00});
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    loadAndExpect(16'h2548, 4'h0, 4'h0, 1'b0, 4'd15, "ack_2548",
                  lit(8'hFE, 8'h80, 30), lit(8'hFD, 8'h99, 30), lit(8'hFB, 8'h92, 30), lit(8'hF7, 8'hA4, 30));
    loadAndExpect(16'h2548, 4'h0, 4'h0, 1'b0, 4'd0, "ack_bright0",
                  dark(), dark(), dark(), dark());
    loadAndExpect(16'h2548, 4'h0, 4'h0, 1'b0, 4'd8, "ack_bright8",
                  lit(8'hFE, 8'h80, 16), lit(8'hFD, 8'h99, 16), lit(8'hFB, 8'h92, 16), lit(8'hF7, 8'hA4, 16));
    loadAndExpect(16'h0040, 4'h0, 4'h0, 1'b1, 4'd15, "ack_lz0040",
                  lit(8'hFE, 8'hC0, 30), lit(8'hFD, 8'h99, 30), dark(), dark());
    loadAndExpect(16'h0000, 4'h0, 4'h0, 1'b1, 4'd15, "ack_lz0000",
                  lit(8'hFE, 8'hC0, 30), dark(), dark(), dark());
    loadAndExpect(16'h0040, 4'b0100, 4'h0, 1'b1, 4'd15, "ack_lz_dp2",
                  lit(8'hFE, 8'hC0, 30), lit(8'hFD, 8'h99, 30), lit(8'hFB, 8'h40, 30), dark());
    loadAndExpect(16'h1111, 4'h0, 4'b0010, 1'b0, 4'd15, "ack_blank1",
                  lit(8'hFE, 8'hF9, 30), dark(), lit(8'hFB, 8'hF9, 30), lit(8'hF7, 8'hF9, 30));

    // Two loads inside one frame, then input churn with no load.
    waitFrame("frame_before_double_load");
    pushFrame(lit(8'hFE, 8'hF9, 30), dark(), lit(8'hFB, 8'hF9, 30), lit(8'hF7, 8'hF9, 30));
    repeat (40) @(negedge clk);
    ack_q.push_back(1'b1);
    applyStimulus(16'h1234, 4'h0, 4'h0, 1'b0, 4'd15, 1'b1);
    repeat (30) @(negedge clk);
    applyStimulus(16'hABCD, 4'h0, 4'h0, 1'b0, 4'd15, 1'b1);
    repeat (20) @(negedge clk);
    applyStimulus(16'h9999, 4'hF, 4'h0, 1'b1, 4'd3, 1'b0);
    waitAck("ack_double_load");
    pushFrame(lit(8'hFE, 8'hA1, 30), lit(8'hFD, 8'hC6, 30), lit(8'hFB, 8'h83, 30), lit(8'hF7, 8'h88, 30));
    waitFrame("frame_after_double_load");
    pushFrame(lit(8'hFE, 8'hA1, 30), lit(8'hFD, 8'hC6, 30), lit(8'hFB, 8'h83, 30), lit(8'hF7, 8'h88, 30));

    // Reset while a digit is lit and a load is still pending.
    waitFrame("frame_before_reset");
    repeat (40) @(negedge clk);
    applyStimulus(16'h5555, 4'h0, 4'h0, 1'b0, 4'd15, 1'b1);
    n = 0;
    while (anode === 8'hFF && n < SLOT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("lit_before_reset", 64'(anode !== 8'hFF), 64'd1);
    #2;
    rst_q.push_back({8'hFF, 8'hFF, 2'b00});
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    waitFrame("frame_after_reset");
    pushFrame(lit(8'hFE, 8'hC0, 30), lit(8'hFD, 8'hC0, 30), lit(8'hFB, 8'hC0, 30), lit(8'hF7, 8'hC0, 30));
    waitFrame("frame_final");
    repeat (5) @(negedge clk);

    checkOutput("slot_queue_drained", 64'(slot_q.size()), 64'd0);
    checkOutput("ack_queue_drained", 64'(ack_q.size()), 64'd0);
    checkOutput("reset_queue_drained", 64'(rst_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Parametrised time-multiplexed 7-segment driver. Successor to the fixed 4-digit display mux.
- Scans NUM_DIGITS hex digits onto one shared 8-bit active-low cathode bus and an 8-bit active-low anode bus.
- Adds per-digit decimal point, blank mask, leading-zero suppression, 16-level brightness PWM, an anti-ghosting blank phase, and tear-free frame-synchronous loading.
- Sits between processor-visible output registers and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of scanned digits; legal range 1..8.
- SUB_CYCLES, 1024, clk cycles per brightness sub-phase. Slot = 16*SUB_CYCLES cycles. Frame = NUM_DIGITS slots.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- digits  in  4*NUM_DIGITS  hex nibbles; digit i = digits[4i+3:4i]; digit 0 is rightmost.
- dp  in  NUM_DIGITS  decimal point enable per digit.
- blank  in  NUM_DIGITS  force digit i dark.
- lz_en  in  1  leading-zero suppression enable.
- brightness  in  4  on-phases per slot, 0..15.
- load  in  1  single-cycle strobe; captures digits/dp/blank/lz_en/brightness.
- anode  out  8  active-low digit enables; bit i = digit i.
- cathode  out  8  active-low segments; bit0=a … bit6=g, bit7=dp.
- load_ack  out  1  one-cycle pulse when staged data becomes displayed.
- frame_tick  out  1  one-cycle pulse at each frame start.

Behaviour:
- Reset (reset=0, async):
  - anode=8'hFF, cathode=8'hFF, load_ack=0, frame_tick=0.
  - All counters 0, pending=0.
  - Staging and shadow: digits 0, dp 0, blank 0, lz_en 0, brightness 4'hF.
- Counters:
  - sub counter 0..SUB_CYCLES-1.
  - phase p 0..15 advances when sub wraps.
  - Digit index d 0..NUM_DIGITS-1 advances when p wraps 15→0; d wraps to 0.
- Frame boundary: cycle where d=0, p=0, sub=0 (first cycle after reset release counts as one).
- Load and transfer:
  - load=1 copies the inputs into staging and sets pending.
  - At a frame boundary with pending=1, staging→shadow, pending cleared, load_ack pulses on the next cycle.
  - A load on the boundary cycle itself is not transferred then; pending stays/gets set and the transfer happens at the next boundary.
  - Multiple loads in one frame: last wins, single load_ack.
- Display only uses shadow values. Inputs change nothing without load.
- Digit enable: digit d lit when 1 <= p <= brightness_shadow AND not blanked AND not suppressed.
  - p=0 is always dark (ghosting guard).
  - brightness 0 = fully dark.
  - brightness 15 = 15/16 duty.
- Leading-zero suppression, when lz_en_shadow=1:
  - Digit i>0 is suppressed if it and every higher digit are 0 and have dp=0.
  - Digit 0 is never suppressed.
- Hex decode, cathode[6:0] active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - cathode[7] = ~dp_shadow[d].
- Dark cycles: anode=8'hFF and cathode=8'hFF.
- anode bits >= NUM_DIGITS are always 1.
- Outputs are registered: anode/cathode reflect counter state with exactly 1-cycle latency. frame_tick is also registered.
- Reset mid-frame: outputs go dark immediately. Scan restarts at d=0, p=0 after release. Pending load is discarded.

Test Plan (NUM_DIGITS=4, SUB_CYCLES=2; slot=32, frame=128 cycles):
- Reset, then load digits=16'h2548, brightness=15. Required:
  - load_ack 1 cycle after the next boundary.
  - Then per slot: 2 dark cycles, then 30 cycles with digit 0 anode=8'hFE/cathode=8'h80, digit 1 8'hFD/8'h99, digit 2 8'hFB/8'h92, digit 3 8'hF7/8'hA4.
- brightness=0 loaded → anode=8'hFF for an entire frame. brightness=8 → each anode low exactly 16 cycles per slot, starting at slot cycle 2.
- lz_en=1:
  - digits=16'h0040 → digits 3,2 never lit; digit 1 shows 8'h99; digit 0 shows 8'hC0.
  - digits=16'h0000 → only digit 0 lit.
  - dp[2]=1 with 16'h0040 → digit 2 lit with cathode 8'h40.
- Load mid-frame, then load again with different data; inputs change without load afterwards. Required: display unchanged until boundary, then shows second load only, one load_ack, frame_tick every 128 cycles.
- Assert reset mid-slot with digit lit → anode=8'hFF asynchronously. After release: pending cleared, display shows 0000 (cathode 8'hC0) at brightness 15.
- blank=4'b0010 with digits 16'h1111 → anode bit 1 never low; other digits show 8'hF9.
